// File: rtl/add_4_seq_ctrl_if.sv
// Operand/result handshake bundle for add_4_seq_ctrl.
// ADD_SEQ_SUB_EN adds the op_sub request bit.
interface add_4_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
`ifdef ADD_SEQ_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef ADD_SEQ_SUB_EN
    modport master (output in_valid, op_a, op_b, cin, op_sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, op_a, op_b, cin, op_sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, op_a, op_b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, op_a, op_b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/add_4_seq_ctrl.sv
// Sequences one external 4-bit adder slice over a WIDTH-bit add, one nibble per clock, LSB first.
// Define ADD_SEQ_SUB_EN to add subtraction (op_sub) via inverted B nibbles and a forced carry-in.
module add_4_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    add_4_seq_ctrl_if.slave     bus,
    output logic [3:0]          add_in_0,
    output logic [3:0]          add_in_1,
    output logic                add_cin,
    input  logic [3:0]          add_out,
    input  logic                add_cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("add_4_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg, b_reg, sum_q;
    logic             cout_q;
    logic             in_ready_c, out_valid_c;
    logic             last_nib;
    logic             carry_init;
    logic [3:0]       b_nib;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sub_q <= 1'b0;
        else if (state_q == IDLE && bus.in_valid)
            sub_q <= bus.op_sub;
    end

    // Subtract as A + ~B + 1: the caller's cin is dropped in favour of the +1.
    assign carry_init = bus.op_sub ? 1'b1 : bus.cin;
    assign b_nib      = b_reg[4*idx +: 4] ^ {4{sub_q}};
`else
    assign carry_init = bus.cin;
    assign b_nib      = b_reg[4*idx +: 4];
`endif

    assign last_nib      = (idx == LAST_IDX);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        add_in_0    = 4'h0;
        add_in_1    = 4'h0;
        add_cin     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                add_in_0 = a_reg[4*idx +: 4];
                add_in_1 = b_nib;
                add_cin  = carry;
                if (last_nib) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_reg  <= bus.op_a;
                    b_reg  <= bus.op_b;
                    carry  <= carry_init;
                    idx    <= '0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end
                RUN: begin
                    sum_q[4*idx +: 4] <= add_out;
                    carry             <= add_cout;
                    idx               <= idx + 1'b1;
                    if (last_nib) cout_q <= add_cout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_4_seq_ctrl.sv
// Directed bench for add_4_seq_ctrl (WIDTH=16) with a behavioural add_4 slice.
module tb_add_4_seq_ctrl;
    localparam int WIDTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] add_in_0, add_in_1, add_out;
    logic       add_cin, add_cout;
    int         n_chk = 0;
    int         n_fail = 0;

    add_4_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add_4_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_in_0 (add_in_0),
        .add_in_1 (add_in_1),
        .add_cin  (add_cin),
        .add_out  (add_out),
        .add_cout (add_cout)
    );

    // External 4-bit ripple slice
    assign {add_cout, add_out} = {1'b0, add_in_0} + {1'b0, add_in_1} + {4'h0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin      = c;
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub   = s;
`else
        if (s) $display("note: op_sub ignored in add-only build");
`endif
    endtask

    // Accept, check first-nibble slice drive and 4-edge latency, then the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [3:0] exp_in1, input logic exp_cin,
                          input logic [15:0] exp_sum, input logic exp_cout);
        offer(a, b, c, s);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_add_in_0"}, 32'(add_in_0), 32'(a[3:0]));
        chk({tag, "_add_in_1"}, 32'(add_in_1), 32'(exp_in1));
        chk({tag, "_add_cin"}, 32'(add_cin), 32'(exp_cin));
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        end
        step();
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({tag, "_idle_slice"}, 32'(add_in_0), 32'd0);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_slice", 32'({add_in_0, add_in_1, add_cin}), 32'd0);
        rst = 1'b0;
        step();

        run_op("t1", 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h1, 1'b0, 16'h2345, 1'b0);
        drain("t1");
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, 1'b0, 16'h0000, 1'b1);
        drain("t2");
        run_op("t3", 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b1, 16'h0001, 1'b0);
        drain("t3");
        run_op("t3b", 16'h8000, 16'h8000, 1'b1, 1'b0, 4'h0, 1'b1, 16'h0001, 1'b1);
        drain("t3b");

        // Back-pressure: results hold, new offer is refused.
        run_op("t4", 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h1, 1'b0, 16'h2345, 1'b0);
        offer(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_sum", 32'(bus.sum), 32'h2345);
            chk("t4_hold_cout", 32'(bus.cout), 32'd0);
            chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("t4_in_ready_next", 32'(bus.in_ready), 32'd1);
        chk("t4_not_taken", 32'(bus.sum), 32'h2345);
        step();
        chk("t4_still_idle", 32'(bus.in_ready), 32'd1);

        // Reset mid-RUN aborts immediately.
        offer(16'h1234, 16'h1111, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_rst_sum", 32'(bus.sum), 32'd0);
        chk("t5_rst_slice", 32'(add_in_0), 32'd0);
        step();
        rst = 1'b0;
        step();
        run_op("t5", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, 1'b0, 16'h0000, 1'b1);
        drain("t5");

`ifdef ADD_SEQ_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 4'h8, 1'b1, 16'hFFFE, 1'b0);
        drain("t6a");
        run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 4'hA, 1'b1, 16'h0002, 1'b1);
        drain("t6b");
        run_op("t6c", 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h1, 1'b0, 16'h2345, 1'b0);
        drain("t6c");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
